// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS core.
//   Opcode, SPECIAL funct and REGIMM rt-field constants used by the decoders,
//   plus the PC-unit phase encoding carried on the 2-bit `state` bus.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_EXEC1   = 2'd1;
  localparam logic [1:0] ST_EXEC2   = 2'd2;

  // Little-endian bus word -> big-endian MIPS word.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/branch_decode.sv
// branch_decode: combinational jump/branch flag decode of one MIPS word.
//   i_instr : instruction word
//   o_*     : one-hot control flags (all 0 for any non-jump/branch encoding)
// Shared with the ALU control decode, so it depends on nothing but the word.
module branch_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_j,
  output logic        o_jal,
  output logic        o_jr,
  output logic        o_jalr,
  output logic        o_beq,
  output logic        o_bne,
  output logic        o_blez,
  output logic        o_bgtz,
  output logic        o_bltz,
  output logic        o_bgez,
  output logic        o_bltzal,
  output logic        o_bgezal
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];
  assign w_rt = i_instr[20:16];

  always_comb begin
    o_j = 1'b0; o_jal = 1'b0; o_jr = 1'b0; o_jalr = 1'b0;
    o_beq = 1'b0; o_bne = 1'b0; o_blez = 1'b0; o_bgtz = 1'b0;
    o_bltz = 1'b0; o_bgez = 1'b0; o_bltzal = 1'b0; o_bgezal = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        o_jr   = (w_fn == FN_JR);
        o_jalr = (w_fn == FN_JALR);
      end
      OP_REGIMM: begin
        o_bltz   = (w_rt == RT_BLTZ);
        o_bgez   = (w_rt == RT_BGEZ);
        o_bltzal = (w_rt == RT_BLTZAL);
        o_bgezal = (w_rt == RT_BGEZAL);
      end
      OP_J:    o_j    = 1'b1;
      OP_JAL:  o_jal  = 1'b1;
      OP_BEQ:  o_beq  = 1'b1;
      OP_BNE:  o_bne  = 1'b1;
      OP_BLEZ: o_blez = 1'b1;
      OP_BGTZ: o_bgtz = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: instruction fetch + IR + field/branch decode.
//   clk, rst            : clock, synchronous active-high reset
//   state, PC_out       : phase and address from the PC unit
//   address, read       : Avalon-style read master to instruction memory
//   waitrequest,readdata: memory handshake / returned word
//   STALL               : holds the PC unit while a fetch is outstanding
//   fetch_error         : sticky waitrequest timeout
//   instr + fields      : instruction register and decoded fields/flags
module instr_fetch_decode
  import mips_pkg::*;
#(
  parameter bit          SWAP_BYTES     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [31:0] PC_out,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        STALL,
  output logic        fetch_error,
  output logic [31:0] instr,
  output logic [4:0]  rs_idx,
  output logic [4:0]  rt_idx,
  output logic [4:0]  rd_idx,
  output logic [15:0] I_immediate,
  output logic [25:0] J_immediate,
  output logic        J,
  output logic        JAL,
  output logic        JR,
  output logic        JALR,
  output logic        BEQ,
  output logic        BNE,
  output logic        BLEZ,
  output logic        BGTZ,
  output logic        BLTZ,
  output logic        BGEZ,
  output logic        BLTZAL,
  output logic        BGEZAL
);

  // Error fires on the edge that closes the TIMEOUT_CYCLES-th waited cycle,
  // i.e. when the pre-edge count is TIMEOUT_CYCLES-1 and the wait persists.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_instr;
  logic [7:0]  r_wait_cnt;
  logic        r_fetch_error;
  logic        w_fetch;
  logic        w_accept;
  logic [31:0] w_word;

  assign w_fetch  = (state == ST_FETCH);
  assign address  = PC_out;
  assign read     = w_fetch & ~rst & ~r_fetch_error;
  assign w_accept = read & ~waitrequest;
  assign STALL    = rst | r_fetch_error | (w_fetch & ~w_accept);
  assign w_word   = SWAP_BYTES ? bswap32(readdata) : readdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr       <= '0;
      r_wait_cnt    <= '0;
      r_fetch_error <= 1'b0;
    end else begin
      if (w_accept) r_instr <= w_word;
      if (!w_fetch || w_accept) begin
        r_wait_cnt <= '0;
      end else if (read && waitrequest) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
        if (r_wait_cnt == TO_LAST) r_fetch_error <= 1'b1;
      end
    end
  end

  assign fetch_error = r_fetch_error;
  assign instr       = r_instr;
  assign rs_idx      = r_instr[25:21];
  assign rt_idx      = r_instr[20:16];
  assign rd_idx      = r_instr[15:11];
  assign I_immediate = r_instr[15:0];
  assign J_immediate = r_instr[25:0];

  branch_decode u_bdec (
    .i_instr (r_instr),
    .o_j     (J),
    .o_jal   (JAL),
    .o_jr    (JR),
    .o_jalr  (JALR),
    .o_beq   (BEQ),
    .o_bne   (BNE),
    .o_blez  (BLEZ),
    .o_bgtz  (BGTZ),
    .o_bltz  (BLTZ),
    .o_bgez  (BGEZ),
    .o_bltzal(BLTZAL),
    .o_bgezal(BGEZAL)
  );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed bench for instr_fetch_decode.
//   u_dut  : SWAP_BYTES=1 (little-endian bus)
//   u_raw  : SWAP_BYTES=0, same inputs, latches readdata verbatim
// Flags are packed {J,JAL,JR,JALR,BEQ,BNE,BLEZ,BGTZ,BLTZ,BGEZ,BLTZAL,BGEZAL}.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [31:0] PC_out;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] address, s_address;
  logic        read, s_read, STALL, s_STALL, fetch_error, s_fetch_error;
  logic [31:0] instr, s_instr;
  logic [4:0]  rs_idx, rt_idx, rd_idx, s_rs, s_rt, s_rd;
  logic [15:0] I_immediate, s_iimm;
  logic [25:0] J_immediate, s_jimm;
  logic [11:0] flags, s_flags;

  int passed = 0;
  int total  = 0;

  localparam logic [11:0] F_J = 12'h800, F_JR = 12'h200, F_JALR = 12'h100,
                          F_BEQ = 12'h080, F_BLTZ = 12'h008, F_BGEZ = 12'h004,
                          F_BLTZAL = 12'h002, F_BGEZAL = 12'h001;

  always #5 clk = ~clk;

  instr_fetch_decode #(.SWAP_BYTES(1'b1), .TIMEOUT_CYCLES(255)) u_dut (
    .clk(clk), .rst(rst), .state(state), .PC_out(PC_out),
    .address(address), .read(read), .waitrequest(waitrequest),
    .readdata(readdata), .STALL(STALL), .fetch_error(fetch_error),
    .instr(instr), .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .I_immediate(I_immediate), .J_immediate(J_immediate),
    .J(flags[11]), .JAL(flags[10]), .JR(flags[9]), .JALR(flags[8]),
    .BEQ(flags[7]), .BNE(flags[6]), .BLEZ(flags[5]), .BGTZ(flags[4]),
    .BLTZ(flags[3]), .BGEZ(flags[2]), .BLTZAL(flags[1]), .BGEZAL(flags[0])
  );

  instr_fetch_decode #(.SWAP_BYTES(1'b0), .TIMEOUT_CYCLES(255)) u_raw (
    .clk(clk), .rst(rst), .state(state), .PC_out(PC_out),
    .address(s_address), .read(s_read), .waitrequest(waitrequest),
    .readdata(readdata), .STALL(s_STALL), .fetch_error(s_fetch_error),
    .instr(s_instr), .rs_idx(s_rs), .rt_idx(s_rt), .rd_idx(s_rd),
    .I_immediate(s_iimm), .J_immediate(s_jimm),
    .J(s_flags[11]), .JAL(s_flags[10]), .JR(s_flags[9]), .JALR(s_flags[8]),
    .BEQ(s_flags[7]), .BNE(s_flags[6]), .BLEZ(s_flags[5]), .BGTZ(s_flags[4]),
    .BLTZ(s_flags[3]), .BGEZ(s_flags[2]), .BLTZAL(s_flags[1]), .BGEZAL(s_flags[0])
  );

  function automatic logic [31:0] le(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Zero-wait fetch of big-endian word w, then hand off to EXEC1.
  task automatic do_fetch(input logic [31:0] w);
    state = 2'd0; waitrequest = 1'b0; readdata = le(w);
    @(posedge clk); #1;
    state = 2'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 2'd0; PC_out = 32'h0; waitrequest = 1'b0;
    readdata = 32'hDEADBEEF;
    #1;
    total++; if (read !== 1'b0) $display("FAIL reset_read: got %b want 0", read); else passed++;
    total++; if (STALL !== 1'b1) $display("FAIL reset_stall: got %b want 1", STALL); else passed++;
    @(posedge clk); #1;
    total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else passed++;
    total++; if (flags !== 12'h0) $display("FAIL reset_flags: got %h want 0", flags); else passed++;
    total++; if (fetch_error !== 1'b0) $display("FAIL reset_err: got %b want 0", fetch_error); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_jump();
    state = 2'd0; PC_out = 32'h00000010; waitrequest = 1'b0; readdata = 32'h00000008;
    #1;
    total++; if (STALL !== 1'b0) $display("FAIL j_stall: got %b want 0", STALL); else passed++;
    total++; if (read !== 1'b1) $display("FAIL j_read: got %b want 1", read); else passed++;
    total++; if (address !== 32'h10) $display("FAIL j_addr: got %h want 10", address); else passed++;
    @(posedge clk); #1;
    state = 2'd1;
    total++; if (instr !== 32'h08000000) $display("FAIL j_instr: got %h want 08000000", instr); else passed++;
    total++; if (flags !== F_J) $display("FAIL j_flags: got %h want %h", flags, F_J); else passed++;
    total++; if (J_immediate !== 26'h0) $display("FAIL j_jimm: got %h want 0", J_immediate); else passed++;
  endtask

  task automatic test_wait_beq();
    state = 2'd0; PC_out = 32'h00000014; waitrequest = 1'b1; readdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (STALL !== 1'b1) $display("FAIL wait_stall%0d: got %b want 1", i, STALL); else passed++;
      total++; if (instr !== 32'h08000000) $display("FAIL wait_hold%0d: got %h want 08000000", i, instr); else passed++;
      @(posedge clk); #1;
    end
    waitrequest = 1'b0; readdata = le(32'h1085FFFE);
    #1;
    total++; if (STALL !== 1'b0) $display("FAIL wait_stall_end: got %b want 0", STALL); else passed++;
    @(posedge clk); #1;
    state = 2'd1;
    total++; if (flags !== F_BEQ) $display("FAIL beq_flags: got %h want %h", flags, F_BEQ); else passed++;
    total++; if (rs_idx !== 5'd4) $display("FAIL beq_rs: got %0d want 4", rs_idx); else passed++;
    total++; if (rt_idx !== 5'd5) $display("FAIL beq_rt: got %0d want 5", rt_idx); else passed++;
    total++; if (I_immediate !== 16'hFFFE) $display("FAIL beq_imm: got %h want fffe", I_immediate); else passed++;
  endtask

  task automatic test_regimm();
    logic [31:0] w [4];
    logic [11:0] e [4];
    w = '{32'h04110004, 32'h04100004, 32'h04010004, 32'h04000004};
    e = '{F_BGEZAL, F_BLTZAL, F_BGEZ, F_BLTZ};
    for (int i = 0; i < 4; i++) begin
      do_fetch(w[i]);
      total++; if (flags !== e[i]) $display("FAIL regimm%0d: got %h want %h", i, flags, e[i]); else passed++;
    end
  endtask

  task automatic test_special();
    do_fetch(32'h03E00008);
    total++; if (flags !== F_JR) $display("FAIL jr_flags: got %h want %h", flags, F_JR); else passed++;
    total++; if (rs_idx !== 5'd31) $display("FAIL jr_rs: got %0d want 31", rs_idx); else passed++;
    do_fetch(32'h0060F809);
    total++; if (flags !== F_JALR) $display("FAIL jalr_flags: got %h want %h", flags, F_JALR); else passed++;
    total++; if (rd_idx !== 5'd31) $display("FAIL jalr_rd: got %0d want 31", rd_idx); else passed++;
    do_fetch(32'h00000000);
    total++; if (flags !== 12'h0) $display("FAIL nop_flags: got %h want 0", flags); else passed++;
  endtask

  task automatic test_stability();
    do_fetch(32'h12345678);
    total++; if (s_instr !== 32'h78563412) $display("FAIL raw_instr: got %h want 78563412", s_instr); else passed++;
    total++; if (instr !== 32'h12345678) $display("FAIL swap_instr: got %h want 12345678", instr); else passed++;
    do_fetch(32'h1085FFFE);
    for (int s = 1; s <= 3; s++) begin
      state = 2'(s);
      for (int k = 0; k < 2; k++) begin
        readdata = (k == 0) ? 32'hFFFFFFFF : 32'h00000008;
        waitrequest = 1'(k);
        #1;
        total++; if (read !== 1'b0) $display("FAIL hold_read_s%0d: got %b want 0", s, read); else passed++;
        total++; if (STALL !== 1'b0) $display("FAIL hold_stall_s%0d: got %b want 0", s, STALL); else passed++;
        @(posedge clk); #1;
        total++; if (instr !== 32'h1085FFFE) $display("FAIL hold_instr_s%0d: got %h want 1085fffe", s, instr); else passed++;
        total++; if (flags !== F_BEQ) $display("FAIL hold_flags_s%0d: got %h want %h", s, flags, F_BEQ); else passed++;
      end
    end
    state = 2'd1;
  endtask

  task automatic test_timeout_boundary();
    state = 2'd0; waitrequest = 1'b1; readdata = 32'h0;
    repeat (254) @(posedge clk);
    #1;
    waitrequest = 1'b0; readdata = le(32'h0800ABCD);
    #1;
    total++; if (STALL !== 1'b0) $display("FAIL bnd_stall: got %b want 0", STALL); else passed++;
    @(posedge clk); #1;
    state = 2'd1;
    total++; if (fetch_error !== 1'b0) $display("FAIL bnd_err: got %b want 0", fetch_error); else passed++;
    total++; if (instr !== 32'h0800ABCD) $display("FAIL bnd_instr: got %h want 0800abcd", instr); else passed++;
  endtask

  task automatic test_rst_midwait();
    state = 2'd0; waitrequest = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (read !== 1'b0) $display("FAIL rstw_read: got %b want 0", read); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (instr !== 32'h0) $display("FAIL rstw_instr: got %h want 0", instr); else passed++;
    repeat (100) @(posedge clk);
    #1;
    total++; if (fetch_error !== 1'b0) $display("FAIL rstw_cnt: got %b want 0", fetch_error); else passed++;
    state = 2'd1;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    do_fetch(32'h08000001);
    state = 2'd0; waitrequest = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    total++; if (fetch_error !== 1'b0) $display("FAIL to_early: got %b want 0", fetch_error); else passed++;
    @(posedge clk); #1;
    total++; if (fetch_error !== 1'b1) $display("FAIL to_err: got %b want 1", fetch_error); else passed++;
    total++; if (read !== 1'b0) $display("FAIL to_read: got %b want 0", read); else passed++;
    waitrequest = 1'b0; readdata = le(32'h10000000);
    repeat (3) @(posedge clk);
    #1;
    total++; if (STALL !== 1'b1) $display("FAIL to_stall: got %b want 1", STALL); else passed++;
    total++; if (instr !== 32'h08000001) $display("FAIL to_frozen: got %h want 08000001", instr); else passed++;
    total++; if (s_fetch_error !== 1'b1) $display("FAIL to_err_raw: got %b want 1", s_fetch_error); else passed++;
    rst = 1'b1; state = 2'd1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (fetch_error !== 1'b0) $display("FAIL to_clr_err: got %b want 0", fetch_error); else passed++;
    total++; if (STALL !== 1'b0) $display("FAIL to_clr_stall: got %b want 0", STALL); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL to_clr_instr: got %h want 0", instr); else passed++;
  endtask

  initial begin
    rst = 1'b1; state = 2'd0; PC_out = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_jump();
    test_wait_beq();
    test_regimm();
    test_special();
    test_stability();
    test_timeout_boundary();
    test_rst_midwait();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
